// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage with IF/ID pipeline register.
//
// Owns the PC, runs a req/ack handshake with instruction memory and presents
// the fetched instruction to decode. Branch redirects from decode follow MIPS
// single-delay-slot semantics:
//   - the word fetched after a branch is the delay slot (in_delay_o=1);
//   - the fetch after the delay slot uses the branch target.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   stall_i           hazard hold: IF/ID register and PC frozen
//   branch_flag_i     decode: instruction in IF/ID takes a branch/jump
//   branch_addr_i     decode: branch target
//   next_delay_i      decode: next fetched instruction is a delay slot
//   imem_req_o        fetch request (FETCH state only)
//   imem_addr_o       fetch address, equal to the PC
//   imem_ack_i        imem_rdata_i is valid this cycle
//   imem_rdata_i      fetched word
//   pc_o, inst_o      PC and instruction held in IF/ID
//   in_delay_o        IF/ID instruction is a delay slot
//   valid_o           IF/ID holds a real instruction
//   fetch_misalign_o  (IF_ALIGN_CHECK_EN only) misaligned PC detected
//
// Configuration
//   IF_ALIGN_CHECK_EN  when defined, a PC with pc[1:0]!=0 issues no request;
//                      a bubble is loaded with fetch_misalign_o=1 and the
//                      stage parks until reset. When undefined, pc[1:0] are
//                      forwarded unchecked.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_addr_i,
    input  logic        next_delay_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        in_delay_o,
`ifdef IF_ALIGN_CHECK_EN
    output logic        fetch_misalign_o,
`endif
    output logic        valid_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_PARK  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_dly_q, id_dly_d;
    logic        id_valid_q, id_valid_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;
    logic        dly_pend_q, dly_pend_d;
    logic [31:0] hold_q, hold_d;

    logic        misalign_s;
    logic        load_s;
    logic        park_entry_s;
    logic        cap_br_s;
    logic        cap_dly_s;
    logic [31:0] word_s;

`ifdef IF_ALIGN_CHECK_EN
    logic        misalign_q, misalign_d;
    assign misalign_s       = (pc_q[1:0] != 2'b00);
    assign fetch_misalign_o = misalign_q;
`else
    assign misalign_s = 1'b0;
`endif

    // Request is a decode of the state register; reset forces it low at once
    // so an in-flight fetch is dropped and a late ack has nothing to answer.
    assign imem_req_o  = (state_q == S_FETCH) && !misalign_s && !rst;
    assign imem_addr_o = pc_q;

    assign pc_o       = id_pc_q;
    assign inst_o     = id_inst_q;
    assign in_delay_o = id_dly_q;
    assign valid_o    = id_valid_q;

    // Branch/delay information from decode only counts for a live, unstalled
    // instruction in IF/ID.
    assign cap_br_s  = id_valid_q && !stall_i && branch_flag_i;
    assign cap_dly_s = id_valid_q && !stall_i && next_delay_i;

    // Next-state logic: FSM, IF/ID load/bubble, PC and pending redirect flags.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        id_pc_d      = id_pc_q;
        id_inst_d    = id_inst_q;
        id_dly_d     = id_dly_q;
        id_valid_d   = id_valid_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;
        dly_pend_d   = dly_pend_q;
        hold_d       = hold_q;
        load_s       = 1'b0;
        park_entry_s = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        misalign_d   = misalign_q;
`endif
        if (state_q == S_HOLD) begin
            word_s = hold_q;
        end else begin
            word_s = imem_rdata_i;
        end

        case (state_q)
            S_FETCH: begin
                if (misalign_s) begin
                    if (!stall_i) begin
                        park_entry_s = 1'b1;
                        state_d      = S_PARK;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (imem_ack_i) begin
                    if (stall_i) begin
                        // Decode is frozen: keep the word until it can move on.
                        hold_d  = imem_rdata_i;
                        state_d = S_HOLD;
                    end else begin
                        load_s = 1'b1;
                    end
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    load_s  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_PARK: begin
                state_d = S_PARK;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (stall_i) begin
            id_valid_d = id_valid_q;
        end else if (load_s) begin
            id_pc_d    = pc_q;
            id_inst_d  = word_s;
            id_valid_d = 1'b1;
            // A same-cycle capture makes this very word the delay slot.
            id_dly_d   = dly_pend_q || cap_dly_s;
            if (cap_br_s) begin
                pc_d = branch_addr_i;
            end else if (redir_pend_q) begin
                pc_d = redir_tgt_q;
            end else begin
                pc_d = pc_q + 32'd4;
            end
            redir_pend_d = 1'b0;
            dly_pend_d   = 1'b0;
        end else begin
            // No word this cycle: bubble, pc_o keeps its last value unless a
            // misaligned PC is being reported.
            if (park_entry_s) begin
                id_pc_d = pc_q;
            end else begin
                id_pc_d = id_pc_q;
            end
            id_inst_d  = BUBBLE_INST;
            id_valid_d = 1'b0;
            id_dly_d   = 1'b0;
            if (cap_br_s) begin
                redir_pend_d = 1'b1;
                redir_tgt_d  = branch_addr_i;
            end else begin
                redir_pend_d = redir_pend_q;
            end
            if (cap_dly_s) begin
                dly_pend_d = 1'b1;
            end else begin
                dly_pend_d = dly_pend_q;
            end
        end

`ifdef IF_ALIGN_CHECK_EN
        if (park_entry_s) begin
            misalign_d = 1'b1;
        end else begin
            misalign_d = misalign_q;
        end
`endif
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            id_pc_q      <= 32'h0000_0000;
            id_inst_q    <= BUBBLE_INST;
            id_dly_q     <= 1'b0;
            id_valid_q   <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= 32'h0000_0000;
            dly_pend_q   <= 1'b0;
            hold_q       <= 32'h0000_0000;
`ifdef IF_ALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            id_pc_q      <= id_pc_d;
            id_inst_q    <= id_inst_d;
            id_dly_q     <= id_dly_d;
            id_valid_q   <= id_valid_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
            dly_pend_q   <= dly_pend_d;
            hold_q       <= hold_d;
`ifdef IF_ALIGN_CHECK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

endmodule
